vtp_scb_ctrl: RTL

//  Upstream configuration stage for the VTP decoder. Owns the STAGES x NODES switch-control-bit (SCB) array feeding the decoder's scb input.

---
 rtl/vtp_pkg.sv | 40 ++++
 rtl/vtp_scb_ctrl_if.sv | 50 +++++
 rtl/vtp_scb_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/vtp_pkg.sv
// ---------------------------------------------------------------------------
// vtp_pkg
//  Shared types and geometry helpers for the VTP switch-control-bit (SCB)
//  configuration stage and the VTP decoder that consumes its array.
//
//  Contents
//   scb_op_e     command opcodes on the SCB command port
//   scb_state_e  controller FSM states
//   scb_stages() number of switch stages for a given page bitmap size
//   scb_nodes()  number of 2x2 switch nodes per stage
//
//  The decoder sizes its network with the same helpers so that both sides
//  of the o_scb bus always agree on its shape.
// ---------------------------------------------------------------------------
package vtp_pkg;

    typedef enum logic [1:0] {
        OP_WR_STAGE = 2'd0,
        OP_WR_BIT   = 2'd1,
        OP_CLEAR    = 2'd2,
        OP_COMMIT   = 2'd3
    } scb_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SETTLE = 2'd2
    } scb_state_e;

    // One stage per address bit of the page index.
    function automatic int scb_stages(input int bitmap);
        return $clog2(bitmap);
    endfunction

    // Each stage pairs pages up, so there are half as many nodes as pages.
    function automatic int scb_nodes(input int bitmap);
        return bitmap / 2;
    endfunction

endpackage

// File: rtl/vtp_scb_ctrl_if.sv
// ---------------------------------------------------------------------------
// vtp_scb_ctrl_if
//  Valid/ready command port of the SCB configuration stage.
//
//  Signals
//   cmd_valid  master->slave  command valid
//   cmd_ready  slave->master  command ready (controller idle)
//   cmd_op     master->slave  opcode (scb_op_e)
//   cmd_stage  master->slave  target stage index
//   cmd_node   master->slave  target node (WR_BIT only)
//   cmd_data   master->slave  stage word (WR_STAGE); bit 0 is the WR_BIT value
//
//  Modports
//   master  software / allocator side
//   slave   vtp_scb_ctrl side
// ---------------------------------------------------------------------------
interface vtp_scb_ctrl_if #(
    parameter int BITMAP = 128
);
    localparam int STAGES = vtp_pkg::scb_stages(BITMAP);
    localparam int NODES  = vtp_pkg::scb_nodes(BITMAP);
    localparam int STG_W  = $clog2(STAGES);
    localparam int NODE_W = $clog2(NODES);

    logic                 cmd_valid;
    logic                 cmd_ready;
    vtp_pkg::scb_op_e     cmd_op;
    logic [STG_W-1:0]     cmd_stage;
    logic [NODE_W-1:0]    cmd_node;
    logic [NODES-1:0]     cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_stage,
        output cmd_node,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_stage,
        input  cmd_node,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/vtp_scb_ctrl.sv
// ---------------------------------------------------------------------------
// vtp_scb_ctrl
//  Upstream configuration stage for the VTP decoder. Holds a shadow and an
//  active STAGES x NODES switch-control-bit array. Commands edit the shadow
//  bank; COMMIT copies the whole shadow into the active bank in one edge, and
//  the controller then waits out the decoder latency before pulsing
//  o_commit_done so that any translation seen after done uses the new map.
//
//  Ports
//   i_clk          clock
//   i_rstn         synchronous reset, active-low
//   cmd            command port (vtp_scb_ctrl_if.slave)
//   o_scb          active SCB array, straight from the active register
//   o_busy         controller not idle
//   o_commit_done  1-cycle pulse, new map visible at decoder output
//   o_err          1-cycle pulse, WR_STAGE/WR_BIT with an illegal stage index
//
//  FSM
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | ready for commands; writes land in shadow, COMMIT copies
//   ST_CLEAR  | zeroing shadow one stage per cycle, index in cnt_q
//   ST_SETTLE | active bank updated, counting down the decoder latency
// ---------------------------------------------------------------------------
module vtp_scb_ctrl
    import vtp_pkg::*;
#(
    parameter int BITMAP  = 128,
    parameter int DEC_LAT = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rstn,
    vtp_scb_ctrl_if.slave                          cmd,
    output logic [scb_stages(BITMAP)-1:0]
                 [scb_nodes(BITMAP)-1:0]           o_scb,
    output logic                                   o_busy,
    output logic                                   o_commit_done,
    output logic                                   o_err
);

    localparam int STAGES = scb_stages(BITMAP);
    localparam int NODES  = scb_nodes(BITMAP);
    localparam int STG_W  = $clog2(STAGES);

    // One counter serves as the clear index and the settle timer.
    localparam int CNT_W  = $clog2(STAGES + DEC_LAT + 1);

    localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(STAGES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = (DEC_LAT > 0) ? CNT_W'(DEC_LAT - 1) : '0;

    // The stage field can encode indices beyond STAGES-1 when STAGES is not
    // a power of two; compare with one extra bit so the limit fits.
    localparam logic [STG_W:0]   STAGE_LIM   = (STG_W + 1)'(STAGES);

    scb_state_e                   state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [STAGES-1:0][NODES-1:0] shadow_q;
    logic [STAGES-1:0][NODES-1:0] active_q;

    logic accept;
    logic stage_ok;
    logic wr_stage;
    logic wr_bit;
    logic do_commit;
    logic done_d;
    logic err_d;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    always_comb begin
        accept    = cmd.cmd_valid && (state_q == ST_IDLE);
        stage_ok  = ({1'b0, cmd.cmd_stage} < STAGE_LIM);
        wr_stage  = accept && (cmd.cmd_op == OP_WR_STAGE) && stage_ok;
        wr_bit    = accept && (cmd.cmd_op == OP_WR_BIT)   && stage_ok;
        do_commit = accept && (cmd.cmd_op == OP_COMMIT);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    case (cmd.cmd_op)
                        OP_WR_STAGE,
                        OP_WR_BIT: begin
                            err_d = !stage_ok;
                        end
                        OP_CLEAR: begin
                            state_d = ST_CLEAR;
                            cnt_d   = '0;
                        end
                        OP_COMMIT: begin
                            // Without a decoder output register the new map
                            // is visible as soon as o_scb changes.
                            if (DEC_LAT > 0) begin
                                state_d = ST_SETTLE;
                                cnt_d   = SETTLE_LOAD;
                            end else begin
                                done_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            ST_CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd.cmd_ready <= 1'b1;
            o_busy        <= 1'b0;
            o_commit_done <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd.cmd_ready <= (state_d == ST_IDLE);
            o_busy        <= (state_d != ST_IDLE);
            o_commit_done <= done_d;
            o_err         <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Shadow and active banks
    // ------------------------------------------------------------------
    // Writes and CLEAR never overlap: writes are only accepted in IDLE and
    // the clear sweep only runs in CLEAR.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (wr_stage) begin
                shadow_q[cmd.cmd_stage] <= cmd.cmd_data;
            end
            if (wr_bit) begin
                shadow_q[cmd.cmd_stage][cmd.cmd_node] <= cmd.cmd_data[0];
            end
            if (state_q == ST_CLEAR) begin
                shadow_q[cnt_q[STG_W-1:0]] <= '0;
            end
            if (do_commit) begin
                active_q <= shadow_q;
            end
        end
    end

    assign o_scb = active_q;

endmodule
